// File: rtl/window_arbiter_if.sv
// Request/grant bundle between detection channels and the window arbiter.
// i_abort exists only when WINDOW_ARB_ABORT_EN is defined.
interface window_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int OW = $clog2(N_REQ);

    logic             i_ce;
    logic [N_REQ-1:0] i_req;
`ifdef WINDOW_ARB_ABORT_EN
    logic             i_abort;
`endif
    logic [N_REQ-1:0] o_gnt;
    logic [OW-1:0]    o_owner;
    logic             o_active;
    logic [N_REQ-1:0] o_done;

`ifdef WINDOW_ARB_ABORT_EN
    modport master (output i_ce, i_req, i_abort, input o_gnt, o_owner, o_active, o_done);
    modport slave  (input i_ce, i_req, i_abort, output o_gnt, o_owner, o_active, o_done);
`else
    modport master (output i_ce, i_req, input o_gnt, o_owner, o_active, o_done);
    modport slave  (input i_ce, i_req, output o_gnt, o_owner, o_active, o_done);
`endif
endinterface

// File: rtl/window_arbiter.sv
// Non-preemptive round-robin owner of one timed activity window (IDLE -> RUN -> DONE).
// Optional early termination via i_abort when WINDOW_ARB_ABORT_EN is defined.
module window_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WIN_LEN      = 16,
    parameter int WIN_LEN_SIZE = 5
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    window_arbiter_if.slave bus
);
    localparam int OW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_n;
    logic [WIN_LEN_SIZE-1:0] cnt, cnt_n;
    logic [OW-1:0]           last, last_n;
    logic [OW-1:0]           owner, owner_n;
    logic [N_REQ-1:0]        gnt, gnt_n;
    logic [N_REQ-1:0]        done, done_n;
    logic                    active, active_n;

    logic                    found;
    logic [OW-1:0]           winner;
    logic                    end_win;

    // Search upward from last+1 so the most recently served requester ranks lowest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(last) + i) % N_REQ;
            if (!found && bus.i_req[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    always_comb begin
        end_win = 1'b0;
        if (state == RUN) begin
`ifdef WINDOW_ARB_ABORT_EN
            if (bus.i_abort)
                end_win = 1'b1;
            else
`endif
            if (bus.i_ce && cnt == WIN_LEN_SIZE'(WIN_LEN - 1))
                end_win = 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last;
        owner_n  = owner;
        gnt_n    = gnt;
        active_n = active;
        done_n   = '0;
        case (state)
            IDLE: begin
                gnt_n    = '0;
                active_n = 1'b0;
                if (found) begin
                    state_n  = RUN;
                    gnt_n    = N_REQ'(1) << winner;
                    owner_n  = winner;
                    last_n   = winner;
                    active_n = 1'b1;
                    cnt_n    = '0;
                end
            end
            RUN: begin
                if (end_win) begin
                    state_n  = DONE;
                    done_n   = gnt;
                    gnt_n    = '0;
                    active_n = 1'b0;
                    cnt_n    = '0;
                end else if (bus.i_ce) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n  = IDLE;
                gnt_n    = '0;
                active_n = 1'b0;
                cnt_n    = '0;
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                active_n = 1'b0;
                cnt_n    = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= OW'(N_REQ - 1);
            owner  <= '0;
            gnt    <= '0;
            done   <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            last   <= last_n;
            owner  <= owner_n;
            gnt    <= gnt_n;
            done   <= done_n;
            active <= active_n;
        end
    end

    assign bus.o_gnt    = gnt;
    assign bus.o_owner  = owner;
    assign bus.o_active = active;
    assign bus.o_done   = done;
endmodule

// File: tb/tb_window_arbiter.sv
// Directed bench for window_arbiter: window length, round-robin order, i_ce stretch, reset kill, abort.
module tb_window_arbiter;
    localparam int N_REQ   = 4;
    localparam int WIN_LEN = 16;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    window_arbiter_if #(.N_REQ(N_REQ)) bus ();

    window_arbiter #(
        .N_REQ(N_REQ),
        .WIN_LEN(WIN_LEN),
        .WIN_LEN_SIZE(5)
    ) dut (
        .i_clk (clk),
        .i_nrst(nrst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},    32'(bus.o_gnt),    32'h0);
        chk({tag, "_active"}, 32'(bus.o_active), 32'h0);
        chk({tag, "_done"},   32'(bus.o_done),   32'h0);
    endtask

    // Entered at the negedge just after the grant edge; leaves at the IDLE-cycle sample.
    task automatic expect_window(input int own, input int len, input int drop_at,
                                 input logic [3:0] drop_req, input bit toggle_ce);
        for (int i = 0; i < len; i++) begin
            chk("run_gnt",    32'(bus.o_gnt),    32'(1 << own));
            chk("run_owner",  32'(bus.o_owner),  32'(own));
            chk("run_active", 32'(bus.o_active), 32'h1);
            chk("run_done",   32'(bus.o_done),   32'h0);
            if (i == drop_at) bus.i_req = drop_req;
            if (toggle_ce) bus.i_ce = i[0];
            @(negedge clk);
        end
        bus.i_ce = 1'b1;
        chk("done_pulse",  32'(bus.o_done),   32'(1 << own));
        chk("done_gnt",    32'(bus.o_gnt),    32'h0);
        chk("done_active", 32'(bus.o_active), 32'h0);
        @(negedge clk);
        chk_idle("gap");
        chk("gap_owner", 32'(bus.o_owner), 32'(own));
    endtask

    initial begin
        nrst       = 1'b0;
        bus.i_req  = '0;
        bus.i_ce   = 1'b1;
`ifdef WINDOW_ARB_ABORT_EN
        bus.i_abort = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset_owner", 32'(bus.o_owner), 32'h0);
        nrst = 1'b1;
        @(negedge clk);
        chk_idle("idle_noreq");

        // Single requester: two windows back to back, 18-cycle period.
        bus.i_req = 4'b0001;
        @(negedge clk);
        expect_window(0, WIN_LEN, -1, 4'b0000, 1'b0);
        @(negedge clk);
        expect_window(0, WIN_LEN, -1, 4'b0000, 1'b0);

        // Fresh reset, all requesting: 0,1,2,3 in order.
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        bus.i_req = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            expect_window(k, WIN_LEN, -1, 4'b0000, 1'b0);
            if (k == 3) bus.i_req = 4'b1010;
            @(negedge clk);
        end

        // last=3 with 1010: requester 1 first, drops mid-window, then 3.
        expect_window(1, WIN_LEN, 8, 4'b1000, 1'b0);
        @(negedge clk);
        expect_window(3, WIN_LEN, -1, 4'b0000, 1'b0);

        // i_ce toggling: window stretches to 32 cycles.
        bus.i_req = 4'b0100;
        @(negedge clk);
        expect_window(2, 2 * WIN_LEN, -1, 4'b0000, 1'b1);

        // Reset at count 7 kills the window with no done pulse.
        bus.i_req = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("kill_pre_gnt", 32'(bus.o_gnt), 32'h1);
        nrst = 1'b0;
        bus.i_req = 4'b0000;
        #1;
        chk_idle("kill_async");
        chk("kill_owner", 32'(bus.o_owner), 32'h0);
        @(negedge clk);
        chk_idle("kill_hold");
        nrst = 1'b1;
        bus.i_req = 4'b0100;
        @(negedge clk);
        chk("post_kill_gnt",   32'(bus.o_gnt),   32'h4);
        chk("post_kill_owner", 32'(bus.o_owner), 32'h2);
        expect_window(2, WIN_LEN, -1, 4'b0000, 1'b0);
        bus.i_req = 4'b0000;

`ifdef WINDOW_ARB_ABORT_EN
        // Abort at count 5 on owner 3; next grant continues round-robin to 0.
        bus.i_req = 4'b1001;
        @(negedge clk);
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("abort_pre_gnt", 32'(bus.o_gnt), 32'h8);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("abort_done",   32'(bus.o_done),   32'h8);
        chk("abort_active", 32'(bus.o_active), 32'h0);
        chk("abort_gnt",    32'(bus.o_gnt),    32'h0);
        @(negedge clk);
        chk_idle("abort_gap");
        @(negedge clk);
        chk("abort_next_gnt",   32'(bus.o_gnt),   32'h1);
        chk("abort_next_owner", 32'(bus.o_owner), 32'h0);
        bus.i_req = 4'b0000;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
